seg_scan_decoder: RTL and testbench

- Receive side of the multiplexed 7-segment scan interface: watches a one-hot digit-select bus (transistor) and the 7 segment lines (d7sp) of a scanned display.
- Recovers each digit's hex value and presents the latest value of every digit as a register bank, with update and frame-complete strobes.
- Used to read back and self-check the display driver output on-chip, or to decode an external scanned display on uio/ui pins.

---
 rtl/seg_scan_decoder.sv | 139 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment scan bus: recovers each digit's hex value.
// Optional BLANK_DETECT_EN adds a per-digit blank flag for the all-segments-off pattern.
module seg_scan_decoder #(
  parameter int NUM_DIGITS     = 3,
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   transistor,
  input  logic [6:0]              d7sp,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    upd,
  output logic [IW-1:0]           upd_idx,
  output logic                    frame_done,
  output logic                    err,
  output logic                    err_sticky
`ifdef BLANK_DETECT_EN
  ,
  output logic [NUM_DIGITS-1:0]   blank
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                state;
  logic [NUM_DIGITS-1:0] sel_meta, s_sel, cur_sel, mask, next_mask;
  logic [6:0]            seg_meta, s_seg, seg;
  logic [3:0]            cnt;
  logic [IW-1:0]         idx;
  logic                  dec_ok;
  logic [3:0]            dec_val;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'b0;
    endcase
  endfunction

  // Polarity fix happens after the synchronizer so both buses see equal delay.
  always_comb begin
    seg              = SEG_ACTIVE_LOW ? ~s_seg : s_seg;
    {dec_ok, dec_val} = decode(seg);
    next_mask        = mask | cur_sel;
    idx              = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cur_sel[i]) idx = IW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_meta   <= '0;
      s_sel      <= '0;
      seg_meta   <= '0;
      s_seg      <= '0;
      cur_sel    <= '0;
      cnt        <= '0;
      mask       <= '0;
      state      <= IDLE;
      digits     <= '0;
      upd        <= 1'b0;
      upd_idx    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
`ifdef BLANK_DETECT_EN
      blank      <= '0;
`endif
    end else begin
      sel_meta   <= transistor;
      s_sel      <= sel_meta;
      seg_meta   <= d7sp;
      s_seg      <= seg_meta;
      upd        <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: if ($onehot(s_sel)) begin
          cur_sel <= s_sel;
          cnt     <= 4'd1;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (s_sel != cur_sel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 4'(SETTLE_CYCLES)) begin
            // Single sample per select window; HOLD blocks re-capture.
            cnt   <= '0;
            state <= HOLD;
            if (dec_ok
`ifdef BLANK_DETECT_EN
                || seg == 7'h00
`endif
               ) begin
              if (dec_ok) digits[4*idx +: 4] <= dec_val;
`ifdef BLANK_DETECT_EN
              blank[idx] <= !dec_ok;
`endif
              upd     <= 1'b1;
              upd_idx <= idx;
              if (&next_mask) begin
                frame_done <= 1'b1;
                mask       <= '0;
              end else begin
                mask <= next_mask;
              end
            end else begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: if (s_sel != cur_sel) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: default-polarity instance plus an active-low instance.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  transistor;
  logic [6:0]  d7sp, dal;
  logic [11:0] digits, digits_al;
  logic        upd, upd_al, frame_done, fd_al, err, err_al, err_sticky, sticky_al;
  logic [1:0]  upd_idx, idx_al;
`ifdef BLANK_DETECT_EN
  logic [2:0]  blank, blank_al;
`endif

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(3), .SETTLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .transistor(transistor), .d7sp(d7sp), .digits(digits),
    .upd(upd), .upd_idx(upd_idx), .frame_done(frame_done), .err(err), .err_sticky(err_sticky)
`ifdef BLANK_DETECT_EN
    , .blank(blank)
`endif
  );

  seg_scan_decoder #(.NUM_DIGITS(3), .SETTLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .transistor(transistor), .d7sp(dal), .digits(digits_al),
    .upd(upd_al), .upd_idx(idx_al), .frame_done(fd_al), .err(err_al), .err_sticky(sticky_al)
`ifdef BLANK_DETECT_EN
    , .blank(blank_al)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int n_upd, n_fd, fd_on_upd, n_err, first_upd, n_upd_al, n_err_al;
  logic [1:0] last_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_upd = 0; n_fd = 0; fd_on_upd = 0; n_err = 0; first_upd = 0;
    n_upd_al = 0; n_err_al = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (upd) begin
        n_upd++; last_idx = upd_idx;
        if (first_upd == 0) first_upd = i;
      end
      if (frame_done) begin n_fd++; if (upd) fd_on_upd++; end
      if (err) n_err++;
      if (upd_al) n_upd_al++;
      if (err_al) n_err_al++;
    end
  endtask

  initial begin
    rst = 1'b1; transistor = 3'b000; d7sp = 7'h00; dal = 7'h7F;
    clr(); run(2);
    rst = 1'b0;
    chk("rst_digits", digits, 12'h000);
    chk("rst_upd", upd, 0);
    chk("rst_upd_idx", upd_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_sticky", err_sticky, 0);

    // Basic capture from IDLE: upd on the 7th sample after driving.
    run(2); clr();
    transistor = 3'b001; d7sp = 7'h5B; run(10);
    chk("basic_upd_count", n_upd, 1);
    chk("basic_latency", first_upd, 7);
    chk("basic_idx", last_idx, 0);
    chk("basic_digits", digits, 12'h002);

    // Full frame
    transistor = 3'b000; run(4); clr();
    transistor = 3'b001; d7sp = 7'h4F; run(8);
    transistor = 3'b010; d7sp = 7'h66; run(8);
    chk("frame_no_fd_early", n_fd, 0);
    transistor = 3'b100; d7sp = 7'h7F; run(8);
    chk("frame_upd_count", n_upd, 3);
    chk("frame_fd_count", n_fd, 1);
    chk("frame_fd_on_upd", fd_on_upd, 1);
    chk("frame_last_idx", last_idx, 2);
    chk("frame_digits", digits, 12'h843);
    clr();
    transistor = 3'b001; d7sp = 7'h6D; run(8);
    transistor = 3'b010; d7sp = 7'h66; run(8);
    chk("frame2_no_fd_early", n_fd, 0);
    transistor = 3'b100; d7sp = 7'h7F; run(8);
    chk("frame2_fd_count", n_fd, 1);
    chk("frame2_digits", digits, 12'h845);

    // Glitch rejection
    transistor = 3'b000; run(4); clr();
    transistor = 3'b001; d7sp = 7'h06; run(3);
    transistor = 3'b000; run(8);
    chk("glitch_short", n_upd, 0);
    transistor = 3'b011; run(20);
    chk("glitch_multihot", n_upd, 0);
    chk("glitch_digits", digits, 12'h845);

    // Invalid pattern
    transistor = 3'b000; run(4); clr();
    transistor = 3'b010; d7sp = 7'h01; run(10);
    chk("inv_err_count", n_err, 1);
    chk("inv_no_upd", n_upd, 0);
    chk("inv_sticky", err_sticky, 1);
    chk("inv_digits", digits, 12'h845);
    transistor = 3'b000; run(4); clr();
    transistor = 3'b001; d7sp = 7'h3F; run(10);
    chk("inv_sticky_holds", err_sticky, 1);
    chk("inv_then_valid", digits, 12'h840);

    // All-segments-off pattern
    transistor = 3'b000; run(4); clr();
    transistor = 3'b100; d7sp = 7'h00; run(10);
`ifdef BLANK_DETECT_EN
    chk("zero_blank", blank, 3'b100);
    chk("zero_upd", n_upd, 1);
    chk("zero_no_err", n_err, 0);
`else
    chk("zero_err", n_err, 1);
    chk("zero_no_upd", n_upd, 0);
`endif
    chk("zero_digits", digits, 12'h840);

    // Reset mid-settle
    transistor = 3'b000; run(4);
    transistor = 3'b010; d7sp = 7'h5B; run(3);
    rst = 1'b1; run(2);
    chk("mrst_digits", digits, 12'h000);
    chk("mrst_sticky", err_sticky, 0);
    chk("mrst_upd", upd, 0);
    rst = 1'b0; clr(); run(6);
    chk("mrst_no_upd", n_upd, 0);
    run(4);
    chk("mrst_recapture", n_upd, 1);
    chk("mrst_digits2", digits, 12'h020);

    // Active-low instance
    transistor = 3'b000; run(4); clr();
    transistor = 3'b100; dal = 7'h06; run(10);
    chk("al_upd", n_upd_al, 1);
    chk("al_E", digits_al[11:8], 4'hE);
    transistor = 3'b000; run(4);
    transistor = 3'b100; dal = 7'h40; run(10);
    chk("al_0", digits_al[11:8], 4'h0);
`ifdef BLANK_DETECT_EN
    transistor = 3'b000; run(4); clr();
    transistor = 3'b100; dal = 7'h7F; run(10);
    chk("al_blank", blank_al[2], 1);
    chk("al_blank_upd", n_upd_al, 1);
    chk("al_blank_no_err", n_err_al, 0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
